// File: rtl/prog_pkg.sv
// rtl/prog_pkg.sv - shared state, opcode and address tables for the program sequencer
package prog_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [3:0] OP_JUMP   = 4'b0110;
    localparam logic [3:0] OP_BONE   = 4'b1000;
    localparam logic [3:0] OP_BZERO  = 4'b1001;
    localparam logic [8:0] INST_HALT = 9'h1FF;

    localparam int unsigned START_ADDR [3] = '{0, 65, 166};

    // Entry 31 reaches the top of the address space so the PC wrap can be exercised.
    localparam int unsigned TARGET_LUT [32] = '{
        0,   20,  40,  60,  80,  100, 120, 140,
        160, 180, 200, 220, 240, 260, 280, 300,
        4,   64,  360, 380, 400, 420, 440, 460,
        480, 500, 520, 540, 560, 580, 600, 1023
    };

endpackage

// File: rtl/jump_lut.sv
// rtl/jump_lut.sv - combinational branch/jump index to target address lookup
module jump_lut
    import prog_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic [4:0]      idx,
    output logic [PC_W-1:0] addr
);

    assign addr = PC_W'(TARGET_LUT[idx]);

endmodule

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - program counter sequencer with jump/branch decode, stall and cycle counter
module prog_sequencer
    import prog_pkg::*;
#(
    parameter int PC_W   = 10,
    parameter int INST_W = 9
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        ProgSel,
    input  logic [INST_W-1:0] InstOut,
    input  logic              Flag,
    input  logic              Stall,
    output logic [PC_W-1:0]   InstAddress,
    output logic              Running,
    output logic              Done,
    output logic [15:0]       CycleCount
);

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic [15:0]     cnt, cnt_n;
    logic            running_q, done_q;
    logic [PC_W-1:0] target;
    logic [3:0]      opcode;
    logic            start_ok;

    assign opcode   = InstOut[8:5];
    assign start_ok = Start && (ProgSel != 2'd3);

    jump_lut #(.PC_W(PC_W)) u_jump_lut (
        .idx  (InstOut[4:0]),
        .addr (target)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            pc        <= '0;
            cnt       <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            cnt       <= cnt_n;
            running_q <= (state_n == S_RUN);
            done_q    <= (state_n == S_HALTED);
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cnt;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start_ok) begin
                    state_n = S_RUN;
                    pc_n    = PC_W'(START_ADDR[ProgSel]);
                    cnt_n   = '0;
                end
            end
            S_RUN: begin
                // Stalled cycles still count as run time.
                if (cnt != 16'hFFFF) begin
                    cnt_n = cnt + 16'd1;
                end
                if (!Stall) begin
                    if (InstOut == INST_HALT) begin
                        state_n = S_HALTED;
                    end else begin
                        case (opcode)
                            OP_JUMP:  pc_n = target;
                            OP_BONE:  pc_n = Flag ? target : pc + PC_W'(1);
                            OP_BZERO: pc_n = Flag ? pc + PC_W'(1) : target;
                            default:  pc_n = pc + PC_W'(1);
                        endcase
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign InstAddress = pc;
    assign Running     = running_q;
    assign Done        = done_q;
    assign CycleCount  = cnt;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - scoreboard bench for prog_sequencer
module tb_prog_sequencer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  ProgSel;
    logic [8:0]  InstOut;
    logic        Flag;
    logic        Stall;
    logic [9:0]  InstAddress;
    logic        Running;
    logic        Done;
    logic [15:0] CycleCount;

    typedef struct {
        logic [9:0]  addr;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [8:0] NOP   = 9'h000;
    localparam logic [8:0] JMP16 = 9'b011010000;
    localparam logic [8:0] JMP31 = 9'b011011111;
    localparam logic [8:0] BONE  = 9'b100010001;
    localparam logic [8:0] BZERO = 9'b100110001;
    localparam logic [8:0] HALT  = 9'h1FF;

    prog_sequencer #(.PC_W(10), .INST_W(9)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Start       (Start),
        .ProgSel     (ProgSel),
        .InstOut     (InstOut),
        .Flag        (Flag),
        .Stall       (Stall),
        .InstAddress (InstAddress),
        .Running     (Running),
        .Done        (Done),
        .CycleCount  (CycleCount)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".addr"}, 32'(InstAddress), 32'(e.addr));
        check({tag, ".run"},  32'(Running),     32'(e.run));
        check({tag, ".done"}, 32'(Done),        32'(e.done));
        check({tag, ".cnt"},  32'(CycleCount),  32'(e.cnt));
    endtask

    task automatic step(input string tag, input logic [8:0] inst, input logic flag,
                        input logic stall, input logic start, input logic [1:0] sel,
                        input logic [9:0] ea, input logic er, input logic ed,
                        input logic [15:0] ec);
        exp_t e;
        InstOut = inst;
        Flag    = flag;
        Stall   = stall;
        Start   = start;
        ProgSel = sel;
        exp_q.push_back('{addr: ea, run: er, done: ed, cnt: ec});
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check_outputs(tag, e);
        Start = 1'b0;
        Stall = 1'b0;
    endtask

    initial begin
        Reset   = 1'b1;
        Start   = 1'b0;
        ProgSel = 2'd0;
        InstOut = NOP;
        Flag    = 1'b0;
        Stall   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_outputs("reset", '{addr: 10'd0, run: 1'b0, done: 1'b0, cnt: 16'd0});
        Reset = 1'b0;

        step("start1", NOP, 0, 0, 1, 2'd1, 10'd65, 1, 0, 16'd0);
        step("seq66",  NOP, 0, 0, 0, 2'd0, 10'd66, 1, 0, 16'd1);
        step("seq67",  NOP, 0, 0, 0, 2'd0, 10'd67, 1, 0, 16'd2);
        step("jump4",  JMP16, 0, 0, 0, 2'd0, 10'd4, 1, 0, 16'd3);
        step("seq5",   NOP, 0, 0, 0, 2'd0, 10'd5, 1, 0, 16'd4);
        step("seq6",   NOP, 0, 0, 0, 2'd0, 10'd6, 1, 0, 16'd5);
        step("bone_t", BONE, 1, 0, 0, 2'd0, 10'd64, 1, 0, 16'd6);
        step("jump4b", JMP16, 0, 0, 0, 2'd0, 10'd4, 1, 0, 16'd7);
        step("seq5b",  NOP, 0, 0, 0, 2'd0, 10'd5, 1, 0, 16'd8);
        step("seq6b",  NOP, 0, 0, 0, 2'd0, 10'd6, 1, 0, 16'd9);
        step("bone_n", BONE, 0, 0, 0, 2'd0, 10'd7, 1, 0, 16'd10);
        step("bzer_t", BZERO, 0, 0, 0, 2'd0, 10'd64, 1, 0, 16'd11);
        step("bzer_n", BZERO, 1, 0, 0, 2'd0, 10'd65, 1, 0, 16'd12);
        step("jump4c", JMP16, 0, 0, 0, 2'd0, 10'd4, 1, 0, 16'd13);
        for (int i = 0; i < 6; i++) begin
            step("walk", NOP, 0, 0, 0, 2'd0, 10'(5 + i), 1, 0, 16'(14 + i));
        end
        for (int i = 0; i < 3; i++) begin
            step("stall", JMP16, 0, 1, 0, 2'd0, 10'd10, 1, 0, 16'(20 + i));
        end
        step("run_st", NOP, 0, 0, 1, 2'd2, 10'd11, 1, 0, 16'd23);
        step("halt",   HALT, 0, 0, 0, 2'd0, 10'd11, 0, 1, 16'd24);
        step("halted", NOP, 0, 0, 0, 2'd0, 10'd11, 0, 1, 16'd24);
        step("h_sel3", NOP, 0, 0, 1, 2'd3, 10'd11, 0, 1, 16'd24);
        step("start2", NOP, 0, 0, 1, 2'd2, 10'd166, 1, 0, 16'd0);
        step("seq167", NOP, 0, 0, 0, 2'd0, 10'd167, 1, 0, 16'd1);

        #2;
        Reset = 1'b1;
        #1;
        check_outputs("async_rst", '{addr: 10'd0, run: 1'b0, done: 1'b0, cnt: 16'd0});
        @(posedge CLK);
        #1;
        Reset = 1'b0;

        step("i_sel3", NOP, 0, 0, 1, 2'd3, 10'd0, 0, 0, 16'd0);
        step("start0", NOP, 0, 0, 1, 2'd0, 10'd0, 1, 0, 16'd0);
        step("j1023",  JMP31, 0, 0, 0, 2'd0, 10'd1023, 1, 0, 16'd1);
        step("wrap",   NOP, 0, 0, 0, 2'd0, 10'd0, 1, 0, 16'd2);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
